divider_unit: RTL and testbench

- Sequential 32-bit unsigned divider for the DIVU instruction. It is the inverse-direction companion of the shift-add multiplier.
- Uses a restoring shift-subtract algorithm: one quotient bit per clock, 32 iterations.
- Driven by the same 6-bit ALU-control Signal bus as the multiplier.
- Result is captured into a 64-bit HI/LO-style output on an OUT command: HI = remainder, LO = quotient.

---
 rtl/divider_unit.sv | 135 +++++++++++++
 tb/tb_divider_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/divider_unit.sv
// divider_unit: sequential 32-bit unsigned restoring divider (DIVU).
// Produces one quotient bit per clock. On an OUT command the finished
// result is captured into dataOut as {remainder, quotient}.
module divider_unit #(
  parameter logic [5:0] DIVU  = 6'b011011,
  parameter logic [5:0] OUT   = 6'b111111,
  parameter int         WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   dataA,
  input  logic [WIDTH-1:0]   dataB,
  input  logic [5:0]         Signal,
  output logic [2*WIDTH-1:0] dataOut,
  output logic               busy,
  output logic               done,
  output logic               divZero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Count value seen on the edge that completes the final iteration.
  localparam logic [5:0] LAST_COUNT = 6'(WIDTH - 1);

  state_t               state_r, state_nx;
  logic [2*WIDTH-1:0]   rem_r, rem_nx;
  logic [WIDTH-1:0]     dvsr_r, dvsr_nx;
  logic [5:0]           count_r, count_nx;
  logic [2*WIDTH-1:0]   data_out_r, data_out_nx;
  logic                 div_zero_r, div_zero_nx;
  logic                 busy_r, done_r;

  // Shifted upper half and trial difference; one extra bit so that
  // divisors with the MSB set still compare correctly.
  logic [WIDTH:0]       shifted_s;
  logic [WIDTH:0]       diff_s;
  logic                 start_s;

  assign shifted_s = {rem_r[2*WIDTH-1:WIDTH], rem_r[WIDTH-1]};
  assign diff_s    = shifted_s - {1'b0, dvsr_r};
  // A new division may begin only when not already iterating.
  assign start_s   = (Signal == DIVU) && (state_r != RUN);

  // Next-state and datapath update for the IDLE/RUN/DONE controller.
  always_comb begin
    state_nx    = state_r;
    rem_nx      = rem_r;
    dvsr_nx     = dvsr_r;
    count_nx    = count_r;
    data_out_nx = data_out_r;
    div_zero_nx = div_zero_r;

    case (state_r)
      IDLE: begin
        state_nx = IDLE;
      end
      RUN: begin
        if (diff_s[WIDTH] == 1'b0) begin
          rem_nx = {diff_s[WIDTH-1:0], rem_r[WIDTH-2:0], 1'b1};
        end else begin
          rem_nx = {shifted_s[WIDTH-1:0], rem_r[WIDTH-2:0], 1'b0};
        end
        count_nx = count_r + 6'd1;
        if (count_r == LAST_COUNT) begin
          state_nx = DONE;
        end else begin
          state_nx = RUN;
        end
      end
      DONE: begin
        if (Signal == OUT) begin
          data_out_nx = rem_r;
          div_zero_nx = 1'b0;
          state_nx    = IDLE;
        end else begin
          state_nx = DONE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    // Operand load overrides the hold paths of IDLE and DONE; an
    // uncaptured result in DONE is simply discarded.
    if (start_s) begin
      dvsr_nx  = dataB;
      count_nx = 6'd0;
      if (dataB == {WIDTH{1'b0}}) begin
        rem_nx      = {dataA, {WIDTH{1'b1}}};
        div_zero_nx = 1'b1;
        state_nx    = DONE;
      end else begin
        rem_nx      = {{WIDTH{1'b0}}, dataA};
        div_zero_nx = 1'b0;
        state_nx    = RUN;
      end
    end else begin
      dvsr_nx = dvsr_nx;
    end
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      rem_r      <= {(2*WIDTH){1'b0}};
      dvsr_r     <= {WIDTH{1'b0}};
      count_r    <= 6'd0;
      data_out_r <= {(2*WIDTH){1'b0}};
      div_zero_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nx;
      rem_r      <= rem_nx;
      dvsr_r     <= dvsr_nx;
      count_r    <= count_nx;
      data_out_r <= data_out_nx;
      div_zero_r <= div_zero_nx;
      busy_r     <= (state_nx == RUN);
      done_r     <= (state_nx == DONE);
    end
  end

  assign dataOut = data_out_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign divZero = div_zero_r;

endmodule

// File: tb/tb_divider_unit.sv
// tb_divider_unit: directed and randomized checks of divider_unit against
// a plain-arithmetic reference (a / b, a % b, divide-by-zero rule).
module tb_divider_unit;

  localparam logic [5:0] DIVU = 6'b011011;
  localparam logic [5:0] OUT  = 6'b111111;
  localparam logic [5:0] NOP  = 6'b000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dataA, dataB;
  logic [5:0]  Signal;
  logic [63:0] dataOut;
  logic        busy, done, divZero;

  int checks = 0;
  int errors = 0;

  divider_unit dut (
    .clk     (clk),
    .reset   (reset),
    .dataA   (dataA),
    .dataB   (dataB),
    .Signal  (Signal),
    .dataOut (dataOut),
    .busy    (busy),
    .done    (done),
    .divZero (divZero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    return {a % b, a / b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    Signal = DIVU; dataA = a; dataB = b;
    tick();
    Signal = NOP; dataA = $urandom; dataB = $urandom;
  endtask

  // Cycles from the current sample point until done, plus busy samples seen.
  task automatic wait_done(output int n, output int bc);
    n = 0; bc = 0;
    while (!done && n < 40) begin
      if (busy) bc++;
      tick();
      n++;
    end
    if (!done) check("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic capture(input string tag, input logic [63:0] exp);
    Signal = OUT;
    tick();
    Signal = NOP;
    check(tag, dataOut, exp);
    check({tag, "_divzero_clr"}, 64'(divZero), 64'd0);
    check({tag, "_done_clr"}, 64'(done), 64'd0);
  endtask

  task automatic full_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    int n, bc;
    start(a, b);
    wait_done(n, bc);
    check({tag, "_lat"}, 64'(n), (b == 32'd0) ? 64'd0 : 64'd32);
    check({tag, "_divzero"}, 64'(divZero), (b == 32'd0) ? 64'd1 : 64'd0);
    capture(tag, model(a, b));
  endtask

  initial begin
    int n, bc;
    logic [31:0] a, b;
    logic [63:0] held;

    reset = 1'b1; Signal = NOP; dataA = 32'd0; dataB = 32'd0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_dataout", dataOut, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_divzero", 64'(divZero), 64'd0);

    // 100/7 with busy-cycle count and latency
    start(32'd100, 32'd7);
    wait_done(n, bc);
    check("d100_7_lat", 64'(n), 64'd32);
    check("d100_7_busy", 64'(bc), 64'd32);
    capture("d100_7", 64'h00000002_0000000E);

    full_op("dmsb", 32'hFFFFFFFF, 32'h80000000);
    check("dmsb_const", dataOut, 64'h7FFFFFFF_00000001);
    full_op("dby1", 32'hFFFFFFFF, 32'd1);
    check("dby1_const", dataOut, 64'h00000000_FFFFFFFF);

    // divide by zero: immediate DONE, never busy
    start(32'd5, 32'd0);
    check("dz_done", 64'(done), 64'd1);
    check("dz_busy", 64'(busy), 64'd0);
    check("dz_flag", 64'(divZero), 64'd1);
    capture("dz", 64'h00000005_FFFFFFFF);

    // OUT in IDLE and during RUN is ignored
    Signal = OUT; tick(); Signal = NOP;
    check("out_idle", dataOut, 64'h00000005_FFFFFFFF);
    start(32'd3, 32'd10);
    tick(); tick();
    Signal = OUT; tick(); Signal = NOP;
    check("out_run", dataOut, 64'h00000005_FFFFFFFF);
    wait_done(n, bc);
    check("d3_10_lat", 64'(n + 3), 64'd32);
    capture("d3_10", 64'h00000003_00000000);

    // DIVU during RUN is ignored
    start(32'd100, 32'd7);
    repeat (10) tick();
    Signal = DIVU; dataA = 32'd9; dataB = 32'd3;
    tick();
    Signal = NOP;
    wait_done(n, bc);
    check("ign_lat", 64'(n + 11), 64'd32);
    capture("ign_divu", 64'h00000002_0000000E);

    // DIVU in DONE restarts; dataOut untouched until OUT
    start(32'd50, 32'd5);
    wait_done(n, bc);
    start(32'd20, 32'd3);
    check("restart_busy", 64'(busy), 64'd1);
    check("restart_hold", dataOut, 64'h00000002_0000000E);
    wait_done(n, bc);
    check("restart_lat", 64'(n), 64'd32);
    capture("restart", model(32'd20, 32'd3));

    // asynchronous reset mid-RUN
    start(32'd100, 32'd7);
    repeat (15) tick();
    #2 reset = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_dataout", dataOut, 64'd0);
    #2 reset = 1'b0;
    tick();
    full_op("d81_9", 32'd81, 32'd9);
    check("d81_9_const", dataOut, 64'h00000000_00000009);

    // randomized operands against the arithmetic model
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case (i % 4)
        0: b = $urandom_range(1, 255);
        1: b = $urandom | 32'h80000000;
        2: b = (i % 8 == 2) ? 32'd0 : $urandom;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if (i % 5 == 0) a = a >> $urandom_range(0, 31);
      held = dataOut;
      start(a, b);
      repeat ($urandom_range(0, 3)) begin
        Signal = $urandom_range(0, 62) == 27 ? NOP : 6'($urandom_range(0, 62));
        if (Signal == DIVU) Signal = NOP;
        tick();
        Signal = NOP;
        check("rnd_hold", dataOut, held);
      end
      wait_done(n, bc);
      check("rnd_divzero", 64'(divZero), (b == 32'd0) ? 64'd1 : 64'd0);
      capture("rnd", model(a, b));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
